// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the ARM control path: FSM states, ALU/mux codes and
// the registered control word carried by the multicycle decoder.
package arm_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWR,
    S_EXECR, S_EXECI, S_MULWAIT, S_ALUWB, S_BRANCH
  } state_e;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_MUL = 3'b110;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_XOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;
  localparam logic [3:0] CMD_MUL = 4'b1111;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  typedef struct packed {
    logic       irwrite;
    logic       nextpc;
    logic       adrsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
    logic       regw;
    logic       memw;
    logic       branch;
    logic [2:0] aluctrl;
    logic [1:0] flagw;
    logic       mov;
  } ctrl_t;

  function automatic ctrl_t fetch_ctrl();
    ctrl_t c;
    c           = '0;
    c.irwrite   = 1'b1;
    c.nextpc    = 1'b1;
    c.alusrca   = 1'b1;
    c.alusrcb   = SRCB_FOUR;
    c.resultsrc = RES_ALU;
    return c;
  endfunction

endpackage

// File: rtl/multicycle_decode_if.sv
// Instruction-field inputs and control-word outputs of the multicycle decoder.
interface multicycle_decode_if #(parameter int ALUCTRL_W = 3);
  logic [1:0]           Op;
  logic [5:0]           Funct;
  logic [3:0]           Rd;
  logic                 mem_ready;
  logic                 IRWrite, NextPC, AdrSrc, ALUSrcA;
  logic [1:0]           ALUSrcB, ResultSrc;
  logic                 RegW, MemW, Branch, PCS;
  logic [ALUCTRL_W-1:0] ALUControl;
  logic [1:0]           FlagW;
  logic                 mov, illegal, busy;

  modport master (
    output Op, Funct, Rd, mem_ready,
    input  IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
    input  RegW, MemW, Branch, PCS, ALUControl, FlagW, mov, illegal, busy
  );

  modport slave (
    input  Op, Funct, Rd, mem_ready,
    output IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
    output RegW, MemW, Branch, PCS, ALUControl, FlagW, mov, illegal, busy
  );
endinterface

// File: rtl/alu_decode.sv
// Combinational data-processing decode: Funct[4:0] -> ALUControl, FlagW, mov,
// undefined. Outputs ADD/no-flags whenever alu_op_i is low.
module alu_decode
  import arm_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W = 3
) (
  input  logic                 alu_op_i,
  input  logic [4:0]           funct_i,
  output logic [ALUCTRL_W-1:0] alu_ctrl_o,
  output logic [1:0]           flag_w_o,
  output logic                 mov_o,
  output logic                 undef_o
);

  logic [2:0] ctrl;
  logic       s_bit;

  assign s_bit = funct_i[0];

  always_comb begin
    ctrl    = ALU_ADD;
    mov_o   = 1'b0;
    undef_o = 1'b0;
    if (alu_op_i) begin
      case (funct_i[4:1])
        CMD_ADD: ctrl  = ALU_ADD;
        CMD_SUB: ctrl  = ALU_SUB;
        CMD_AND: ctrl  = ALU_AND;
        CMD_ORR: ctrl  = ALU_ORR;
        CMD_MOV: mov_o = 1'b1;
        CMD_XOR: ctrl  = ALU_XOR;
        CMD_MUL: ctrl  = ALU_MUL;
        default: undef_o = 1'b1;
      endcase
    end
  end

  // Undefined commands must not disturb the flags.
  always_comb begin
    flag_w_o = 2'b00;
    if (alu_op_i && !undef_o)
      flag_w_o = {s_bit, s_bit & (ctrl == ALU_ADD || ctrl == ALU_SUB)};
  end

  assign alu_ctrl_o = ALUCTRL_W'(ctrl);

endmodule

// File: rtl/multicycle_decode.sv
// Multicycle ARM control FSM. Control outputs are registered from the next
// state so each state's control word is valid for its whole cycle.
module multicycle_decode
  import arm_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 3,
  parameter int CNT_W      = $clog2(MUL_CYCLES + 1),
  parameter int ALUCTRL_W  = 3
) (
  input  logic               clk,
  input  logic               reset,
  multicycle_decode_if.slave bus
);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  ctrl_t                ctrl_q, ctrl_d;
  logic                 illegal_q, illegal_d;
  logic                 busy_q;

  logic [ALUCTRL_W-1:0] dec_ctrl;
  logic [1:0]           dec_flagw;
  logic                 dec_mov, dec_undef;
  logic                 is_mul;

  alu_decode #(.ALUCTRL_W(ALUCTRL_W)) u_alu_decode (
    .alu_op_i  (bus.Op == OP_DP),
    .funct_i   (bus.Funct[4:0]),
    .alu_ctrl_o(dec_ctrl),
    .flag_w_o  (dec_flagw),
    .mov_o     (dec_mov),
    .undef_o   (dec_undef)
  );

  assign is_mul = (bus.Funct[4:1] == CMD_MUL);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    illegal_d = 1'b0;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (bus.Op)
          OP_MEM:  state_d = S_MEMADR;
          OP_BR:   state_d = S_BRANCH;
          OP_DP:   state_d = bus.Funct[5] ? S_EXECI : S_EXECR;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR:  state_d = bus.Funct[0] ? S_MEMREAD : S_MEMWR;
      S_MEMREAD: if (bus.mem_ready) state_d = S_MEMWB;
      S_MEMWR:   if (bus.mem_ready) state_d = S_FETCH;
      S_EXECR, S_EXECI: begin
        if (dec_undef) begin
          state_d   = S_FETCH;
          illegal_d = 1'b1;
        end else if (is_mul) begin
          state_d = S_MULWAIT;
          cnt_d   = CNT_W'(MUL_CYCLES - 1);
        end else begin
          state_d = S_ALUWB;
        end
      end
      S_MULWAIT: begin
        if (cnt_q == '0) state_d = S_ALUWB;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = S_FETCH;
    endcase
  end

  // MUL flags go out only on the cycle the counter reaches zero.
  always_comb begin
    ctrl_d = '0;
    case (state_d)
      S_FETCH:  ctrl_d = fetch_ctrl();
      S_DECODE: begin
        ctrl_d.alusrca   = 1'b1;
        ctrl_d.alusrcb   = SRCB_FOUR;
        ctrl_d.resultsrc = RES_ALU;
      end
      S_MEMADR: ctrl_d.alusrcb = SRCB_IMM;
      S_MEMREAD: ctrl_d.adrsrc = 1'b1;
      S_MEMWR: begin
        ctrl_d.adrsrc = 1'b1;
        ctrl_d.memw   = 1'b1;
      end
      S_MEMWB: begin
        ctrl_d.resultsrc = RES_RDATA;
        ctrl_d.regw      = 1'b1;
      end
      S_EXECR, S_EXECI, S_MULWAIT: begin
        ctrl_d.alusrcb = bus.Funct[5] ? SRCB_IMM : SRCB_REG;
        ctrl_d.aluctrl = 3'(dec_ctrl);
        ctrl_d.mov     = dec_mov;
        if (state_d == S_MULWAIT)
          ctrl_d.flagw = (cnt_d == '0) ? dec_flagw : 2'b00;
        else if (!is_mul)
          ctrl_d.flagw = dec_flagw;
      end
      S_ALUWB: ctrl_d.regw = 1'b1;
      S_BRANCH: begin
        ctrl_d.alusrcb   = SRCB_IMM;
        ctrl_d.resultsrc = RES_ALU;
        ctrl_d.branch    = 1'b1;
      end
      default: ctrl_d = fetch_ctrl();
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      cnt_q     <= '0;
      ctrl_q    <= fetch_ctrl();
      illegal_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ctrl_q    <= ctrl_d;
      illegal_q <= illegal_d;
      busy_q    <= (state_d != S_FETCH);
    end
  end

  assign bus.IRWrite    = ctrl_q.irwrite;
  assign bus.NextPC     = ctrl_q.nextpc;
  assign bus.AdrSrc     = ctrl_q.adrsrc;
  assign bus.ALUSrcA    = ctrl_q.alusrca;
  assign bus.ALUSrcB    = ctrl_q.alusrcb;
  assign bus.ResultSrc  = ctrl_q.resultsrc;
  assign bus.RegW       = ctrl_q.regw;
  assign bus.MemW       = ctrl_q.memw;
  assign bus.Branch     = ctrl_q.branch;
  assign bus.PCS        = ((bus.Rd == 4'hF) & ctrl_q.regw) | ctrl_q.branch;
  assign bus.ALUControl = ALUCTRL_W'(ctrl_q.aluctrl);
  assign bus.FlagW      = ctrl_q.flagw;
  assign bus.mov        = ctrl_q.mov;
  assign bus.illegal    = illegal_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_multicycle_decode.sv
// Bench for multicycle_decode: per-instruction cycle timelines built from the
// instruction-class rules, compared cycle by cycle against the DUT outputs.
module tb_multicycle_decode;

  localparam int MULC = 3;

  logic clk;
  logic reset;

  multicycle_decode_if #(.ALUCTRL_W(3)) bus ();

  multicycle_decode #(.MUL_CYCLES(MULC), .ALUCTRL_W(3)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       irw, npc, adr, srca;
    logic [1:0] srcb, res;
    logic       regw, memw, br, pcs;
    logic [2:0] aluc;
    logic [1:0] flagw;
    logic       mov, ill, busy;
  } out_t;

  int   checks = 0;
  int   errors = 0;
  bit   pend_ill = 1'b0;
  out_t exp_q[$];
  bit   mr_q[$];

  function automatic out_t obs();
    out_t o;
    o.irw = bus.IRWrite;  o.npc = bus.NextPC;  o.adr = bus.AdrSrc;
    o.srca = bus.ALUSrcA; o.srcb = bus.ALUSrcB; o.res = bus.ResultSrc;
    o.regw = bus.RegW;    o.memw = bus.MemW;    o.br = bus.Branch;
    o.pcs = bus.PCS;      o.aluc = bus.ALUControl; o.flagw = bus.FlagW;
    o.mov = bus.mov;      o.ill = bus.illegal;  o.busy = bus.busy;
    return o;
  endfunction

  function automatic out_t busy_rec();
    out_t o = '0;
    o.busy = 1'b1;
    return o;
  endfunction

  function automatic out_t fetch_rec(input bit ill);
    out_t o = '0;
    o.irw = 1'b1; o.npc = 1'b1; o.srca = 1'b1;
    o.srcb = 2'b10; o.res = 2'b10; o.ill = ill;
    return o;
  endfunction

  // Data-processing command table: returns 0 for an undefined command.
  function automatic bit cmd_info(input logic [3:0] cmd, output logic [2:0] aluc, output logic mv);
    aluc = 3'b000;
    mv   = 1'b0;
    case (cmd)
      4'b0100: aluc = 3'b000;
      4'b0010: aluc = 3'b001;
      4'b0000: aluc = 3'b010;
      4'b1100: aluc = 3'b011;
      4'b1101: mv   = 1'b1;
      4'b0001: aluc = 3'b100;
      4'b1111: aluc = 3'b110;
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  task automatic push(input out_t o, input bit mr);
    exp_q.push_back(o);
    mr_q.push_back(mr);
  endtask

  task automatic build(input logic [1:0] op, input logic [5:0] f, input logic [3:0] rd, input int stalls);
    out_t       o;
    logic [2:0] ac;
    logic       mv;
    bit         ok;
    exp_q.delete();
    mr_q.delete();
    push(fetch_rec(pend_ill), 1'($urandom_range(0, 1)));
    pend_ill = 1'b0;
    o = busy_rec(); o.srca = 1'b1; o.srcb = 2'b10; o.res = 2'b10;
    push(o, 1'($urandom_range(0, 1)));
    case (op)
      2'b01: begin
        o = busy_rec(); o.srcb = 2'b01;
        push(o, 1'($urandom_range(0, 1)));
        for (int i = 0; i <= stalls; i++) begin
          o = busy_rec(); o.adr = 1'b1; o.memw = !f[0];
          push(o, i == stalls);
        end
        if (f[0]) begin
          o = busy_rec(); o.res = 2'b01; o.regw = 1'b1; o.pcs = (rd == 4'hF);
          push(o, 1'($urandom_range(0, 1)));
        end
      end
      2'b10: begin
        o = busy_rec(); o.srcb = 2'b01; o.res = 2'b10; o.br = 1'b1; o.pcs = 1'b1;
        push(o, 1'($urandom_range(0, 1)));
      end
      2'b11: pend_ill = 1'b1;
      default: begin
        ok = cmd_info(f[4:1], ac, mv);
        o = busy_rec(); o.srcb = f[5] ? 2'b01 : 2'b00; o.aluc = ac; o.mov = mv;
        if (!ok) begin
          push(o, 1'($urandom_range(0, 1)));
          pend_ill = 1'b1;
        end else begin
          if (f[4:1] == 4'hF) begin
            push(o, 1'($urandom_range(0, 1)));
            for (int k = 0; k < MULC; k++) begin
              o.flagw = (k == MULC - 1) ? {f[0], 1'b0} : 2'b00;
              push(o, 1'($urandom_range(0, 1)));
            end
          end else begin
            o.flagw = {f[0], f[0] & (ac <= 3'b001)};
            push(o, 1'($urandom_range(0, 1)));
          end
          o = busy_rec(); o.regw = 1'b1; o.pcs = (rd == 4'hF);
          push(o, 1'($urandom_range(0, 1)));
        end
      end
    endcase
  endtask

  task automatic check(input string tag, input out_t got, input out_t exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%05h expected=%05h", tag, got, exp);
    end
  endtask

  task automatic run(input string tag, input logic [1:0] op, input logic [5:0] f,
                     input logic [3:0] rd, input int stalls);
    build(op, f, rd, stalls);
    foreach (exp_q[i]) begin
      @(negedge clk);
      if (i == 0) begin
        bus.Op = op; bus.Funct = f; bus.Rd = rd;
      end
      bus.mem_ready = mr_q[i];
      #1;
      check($sformatf("%s[%0d]", tag, i), obs(), exp_q[i]);
    end
  endtask

  initial begin
    out_t o;
    reset = 1'b0;
    bus.Op = 2'b00; bus.Funct = 6'b0; bus.Rd = 4'h0; bus.mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("reset", obs(), fetch_rec(1'b0));
    @(posedge clk); #1 reset = 1'b1;

    run("add_s",    2'b00, 6'b101001, 4'h3, 0);
    run("vmul",     2'b00, 6'b011111, 4'h2, 0);
    run("ldr_stl2", 2'b01, 6'b000001, 4'h4, 2);
    run("str_stl1", 2'b01, 6'b000000, 4'h5, 1);
    run("branch",   2'b10, 6'b000000, 4'h0, 0);
    run("add_pc",   2'b00, 6'b001000, 4'hF, 0);
    run("op11",     2'b11, 6'b000000, 4'h1, 0);
    run("cmd1010",  2'b00, 6'b010100, 4'h1, 0);
    run("mov_imm",  2'b00, 6'b111010, 4'h1, 0);
    run("ldr_pc",   2'b01, 6'b000001, 4'hF, 0);
    run("sub_s",    2'b00, 6'b000101, 4'h6, 0);

    // Store stalled in MEMWR, then reset lands mid-cycle.
    @(negedge clk);
    bus.Op = 2'b01; bus.Funct = 6'b000000; bus.Rd = 4'h7; bus.mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    o = busy_rec(); o.adr = 1'b1; o.memw = 1'b1;
    check("memwr_stall", obs(), o);
    #1 reset = 1'b0;
    #1 check("reset_mid_memwr", obs(), fetch_rec(1'b0));
    pend_ill = 1'b0;
    @(posedge clk); #1 reset = 1'b1;

    for (int n = 0; n < 150; n++)
      run("rand", 2'($urandom_range(0, 3)), 6'($urandom), 4'($urandom), $urandom_range(0, 3));

    @(negedge clk); #1;
    check("final_fetch", obs(), fetch_rec(pend_ill));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
